// File: rtl/event_counter_bank.sv
// Bank of independent up-counters for cycle/event profiling, with
// sticky overflow, compare-match pulse and a frozen snapshot read port.
module event_counter_bank #(
  parameter  int NUM_CH   = 4,
  parameter  int WIDTH    = 32,
  parameter  int SATURATE = 0,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [WIDTH-1:0]        cmp_val,
  input  logic                    snap,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       hit,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_ovf
);

  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [WIDTH-1:0]  scnt_q [NUM_CH];
  logic [WIDTH-1:0]  scnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] hit_q, hit_d;
  logic [NUM_CH-1:0] sovf_q, sovf_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_ovf_q, rd_ovf_d;
  logic [WIDTH-1:0]  nxt;

  always_comb begin
    ovf_d  = ovf_q;
    hit_d  = '0;
    sovf_d = snap ? ovf_q : sovf_q;
    nxt    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      scnt_d[i] = snap ? cnt_q[i] : scnt_q[i];
      nxt       = cnt_q[i] + WIDTH'(1);
      if (clr[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en[i] && inc[i]) begin
        if (cnt_q[i] != '1) begin
          cnt_d[i] = nxt;
          hit_d[i] = (nxt == cmp_val);
        end else begin
          ovf_d[i] = 1'b1;
          // Saturated re-increment leaves the count unchanged: no hit.
          if (SATURATE == 0) begin
            cnt_d[i] = '0;
            hit_d[i] = (cmp_val == '0);
          end
        end
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = scnt_q[i];
        rd_ovf_d  = sovf_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        scnt_q[i] <= '0;
      end
      ovf_q     <= '0;
      hit_q     <= '0;
      sovf_q    <= '0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        scnt_q[i] <= scnt_d[i];
      end
      ovf_q     <= ovf_d;
      hit_q     <= hit_d;
      sovf_q    <= sovf_d;
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign count[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign ovf     = ovf_q;
  assign hit     = hit_q;
  assign rd_data = rd_data_q;
  assign rd_ovf  = rd_ovf_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Directed bench: 32-bit wrap bank plus 4-bit wrap and 4-bit
// saturating banks, all three channels wide, sharing stimulus.
module tb_event_counter_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  en, inc, clr;
  logic [31:0] cmp32;
  logic [3:0]  cmp4;
  logic        snap;
  logic [1:0]  rd_sel;

  logic [95:0] count_a;
  logic [2:0]  ovf_a, hit_a;
  logic [31:0] rd_a;
  logic        rdo_a;

  logic [11:0] count_w;
  logic [2:0]  ovf_w, hit_w;
  logic [3:0]  rd_w;
  logic        rdo_w;

  logic [11:0] count_s;
  logic [2:0]  ovf_s, hit_s;
  logic [3:0]  rd_s;
  logic        rdo_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  event_counter_bank #(.NUM_CH(3), .WIDTH(32), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .clr(clr),
    .cmp_val(cmp32), .snap(snap), .rd_sel(rd_sel),
    .count(count_a), .ovf(ovf_a), .hit(hit_a),
    .rd_data(rd_a), .rd_ovf(rdo_a)
  );

  event_counter_bank #(.NUM_CH(3), .WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .clr(clr),
    .cmp_val(cmp4), .snap(snap), .rd_sel(rd_sel),
    .count(count_w), .ovf(ovf_w), .hit(hit_w),
    .rd_data(rd_w), .rd_ovf(rdo_w)
  );

  event_counter_bank #(.NUM_CH(3), .WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .clr(clr),
    .cmp_val(cmp4), .snap(snap), .rd_sel(rd_sel),
    .count(count_s), .ovf(ovf_s), .hit(hit_s),
    .rd_data(rd_s), .rd_ovf(rdo_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [31:0] exp_rd [4];
  logic [31:0] prev;

  initial begin
    reset  = 1'b1;
    en     = '0;
    inc    = '0;
    clr    = '0;
    cmp32  = 32'd5;
    cmp4   = 4'd15;
    snap   = 1'b0;
    rd_sel = '0;
    tick();
    chk("rst_count", count_a, 96'd0);
    chk("rst_ovf", {93'd0, ovf_a}, 96'd0);
    chk("rst_hit", {93'd0, hit_a}, 96'd0);
    chk("rst_rd", {64'd0, rd_a}, 96'd0);
    chk("rst_rdovf", {95'd0, rdo_a}, 96'd0);
    reset = 1'b0;

    // 1: ten counts on ch0, hit when it reaches 5, then hold
    en  = 3'b001;
    inc = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t1_hit", {93'd0, hit_a}, (k == 5) ? 96'd1 : 96'd0);
    end
    chk("t1_count10", count_a, 96'd10);
    en = 3'b000;
    repeat (3) tick();
    chk("t1_hold", count_a, 96'd10);
    cmp32 = 32'd10;
    tick();
    chk("t1_cmpchg_nohit", {93'd0, hit_a}, 96'd0);

    // 2/3: 20 increments on ch1 of the 4-bit banks
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en  = 3'b010;
    inc = 3'b010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t2_wrap_cnt", {92'd0, count_w[7:4]}, 96'(k % 16));
      chk("t2_wrap_ovf", {95'd0, ovf_w[1]}, (k >= 16) ? 96'd1 : 96'd0);
      chk("t3_sat_cnt", {92'd0, count_s[7:4]}, (k >= 15) ? 96'd15 : 96'(k));
      chk("t3_sat_ovf", {95'd0, ovf_s[1]}, (k >= 16) ? 96'd1 : 96'd0);
      chk("t3_sat_hit", {93'd0, hit_s}, (k == 15) ? 96'd2 : 96'd0);
    end
    snap = 1'b1;
    tick();
    chk("t2_snap_inc", {92'd0, count_w[7:4]}, 96'd5);
    snap   = 1'b0;
    clr    = 3'b010;
    rd_sel = 2'd1;
    tick();
    chk("t2_clr_cnt", {84'd0, count_w}, 96'd0);
    chk("t2_clr_ovf", {93'd0, ovf_w}, 96'd0);
    chk("t3_clr_cnt", {84'd0, count_s}, 96'd0);
    chk("t2_rd_snap", {92'd0, rd_w}, 96'd4);
    chk("t2_rd_ovf", {95'd0, rdo_w}, 96'd1);
    chk("t3_rd_snap", {92'd0, rd_s}, 96'd15);
    chk("t3_rd_ovf", {95'd0, rdo_s}, 96'd1);
    clr = 3'b000;

    // 4: channels at 3/5/7, then clr+inc+snap on ch2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en  = 3'b111;
    inc = 3'b111;
    repeat (3) tick();
    inc = 3'b110;
    repeat (2) tick();
    inc = 3'b100;
    repeat (2) tick();
    chk("t4_pre", count_a, {32'd7, 32'd5, 32'd3});
    clr    = 3'b100;
    snap   = 1'b1;
    rd_sel = 2'd2;
    tick();
    chk("t4_clr_beats_inc", count_a, {32'd0, 32'd5, 32'd3});
    chk("t4_rd_prev_snap", {64'd0, rd_a}, 96'd0);
    clr  = 3'b000;
    snap = 1'b0;
    inc  = 3'b000;
    tick();
    chk("t4_rd_ch2", {64'd0, rd_a}, 96'd7);
    chk("t4_rdovf_ch2", {95'd0, rdo_a}, 96'd0);

    // 5: back-to-back reads, including out-of-range select
    exp_rd[0] = 32'd3;
    exp_rd[1] = 32'd5;
    exp_rd[2] = 32'd7;
    exp_rd[3] = 32'd0;
    prev = 32'd7;
    for (int j = 3; j >= 0; j--) begin
      rd_sel = 2'(j);
      #1;
      chk("t5_rd_late", {64'd0, rd_a}, {64'd0, prev});
      tick();
      chk("t5_rd", {64'd0, rd_a}, {64'd0, exp_rd[j]});
      prev = exp_rd[j];
    end
    for (int j = 0; j < 4; j++) begin
      rd_sel = 2'(j);
      tick();
      chk("t5_seq", {64'd0, rd_a}, {64'd0, exp_rd[j]});
    end

    // 6: reset mid-count
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en  = 3'b001;
    inc = 3'b001;
    repeat (123) tick();
    chk("t6_123", count_a, 96'd123);
    snap = 1'b1;
    tick();
    snap   = 1'b0;
    rd_sel = 2'd0;
    tick();
    chk("t6_rd_123", {64'd0, rd_a}, 96'd123);
    chk("t6_live_125", count_a, 96'd125);
    reset = 1'b1;
    tick();
    chk("t6_rst_count", count_a, 96'd0);
    chk("t6_rst_ovf", {93'd0, ovf_a}, 96'd0);
    chk("t6_rst_hit", {93'd0, hit_a}, 96'd0);
    chk("t6_rst_rd", {64'd0, rd_a}, 96'd0);
    reset = 1'b0;
    tick();
    chk("t6_resume", count_a, 96'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
